channel_scanner: RTL

CHANNEL_SCANNER -- requirements
Module: channel_scanner

---
 rtl/channel_scanner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/channel_scanner.sv
`default_nettype none
// ============================================================================
// Module      : channel_scanner
// Description : Round-robin scanner over a 4x1 mux. Drives the select, waits
//               a fixed dwell time, captures the mux output and hands it to a
//               consumer with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module channel_scanner #(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   req,
  input  logic [N-1:0] Y,
  input  logic         ready,
  output logic [1:0]   S,
  output logic [N-1:0] data_out,
  output logic [1:0]   ch_out,
  output logic         valid
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_settle = 2'd1;
  localparam logic [1:0] c_wait   = 2'd2;
  localparam logic [7:0] c_last   = 8'(DWELL - 1);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [7:0]   r_cnt;
  logic [7:0]   w_cnt_nxt;
  logic [1:0]   r_s;
  logic [1:0]   w_s_nxt;
  logic [N-1:0] r_data;
  logic [N-1:0] w_data_nxt;
  logic [1:0]   r_ch;
  logic [1:0]   w_ch_nxt;
  logic         r_valid;
  logic         w_valid_nxt;

  logic         w_start;
  logic         w_dwell_done;
  logic [1:0]   w_next_ch;

  // Search order is S+1, S+2, S+3, then S itself; the nearest requester wins.
  function automatic logic [1:0] next_channel(input logic [1:0] cur,
                                              input logic [3:0] mask);
    logic [1:0] cand;
    next_channel = cur;
    for (int k = 4; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (mask[cand]) next_channel = cand;
    end
  endfunction

  assign w_start      = en && (req != 4'b0000);
  assign w_dwell_done = (r_cnt == c_last);
  assign w_next_ch    = next_channel(r_s, req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_cnt   <= 8'd0;
      r_s     <= 2'b11;
      r_data  <= '0;
      r_ch    <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
      r_data  <= w_data_nxt;
      r_ch    <= w_ch_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (w_start) w_state_nxt = c_settle;
      end
      c_settle: begin
        if (!en)               w_state_nxt = c_idle;
        else if (w_dwell_done) w_state_nxt = c_wait;
      end
      c_wait: begin
        if (ready) w_state_nxt = w_start ? c_settle : c_idle;
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // Next values of the registered outputs; everything holds unless told otherwise.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;
    w_data_nxt  = r_data;
    w_ch_nxt    = r_ch;
    w_valid_nxt = r_valid;
    case (r_state)
      c_idle: begin
        w_valid_nxt = 1'b0;
        if (w_start) begin
          w_s_nxt   = w_next_ch;
          w_cnt_nxt = 8'd0;
        end
      end
      c_settle: begin
        if (en) begin
          if (w_dwell_done) begin
            w_data_nxt  = Y;
            w_ch_nxt    = r_s;
            w_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      c_wait: begin
        if (ready) begin
          w_valid_nxt = 1'b0;
          if (w_start) begin
            w_s_nxt   = w_next_ch;
            w_cnt_nxt = 8'd0;
          end
        end
      end
      default: w_valid_nxt = 1'b0;
    endcase
  end

  assign S        = r_s;
  assign data_out = r_data;
  assign ch_out   = r_ch;
  assign valid    = r_valid;

endmodule
`default_nettype wire
